// File: rtl/gtp_drp_rmw.sv
// DRP master for GTPE2_COMMON: accepts masked update requests and performs a read or a
// read-modify-write on the DRP port, returning the pre-modify data and a timeout flag.
module gtp_drp_rmw #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_mask,
  input  logic              req_rd_only,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] drp_addr,
  output logic [DATA_W-1:0] drp_di,
  output logic              drp_en,
  output logic              drp_we,
  input  logic [DATA_W-1:0] drp_do,
  input  logic              drp_rdy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, mask_q, di_q, rdata_q;
  logic                rd_only_q, err_q;
  logic                timeout;

  // Asserted on the TIMEOUT-th consecutive wait cycle without drp_rdy.
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_valid) state_d = StRdReq;
      StRdReq:  state_d = StRdWait;
      StRdWait: begin
        if (drp_rdy)      state_d = rd_only_q ? StDone : StWrReq;
        else if (timeout) state_d = StDone;
      end
      StWrReq:  state_d = StWrWait;
      StWrWait: if (drp_rdy || timeout) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // DRP strobes decode straight from state so a reset drops them without waiting for a clock.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    drp_en    = (state_q == StRdReq) || (state_q == StWrReq);
    drp_we    = (state_q == StWrReq);
    rsp_valid = (state_q == StDone);
    rsp_err   = (state_q == StDone) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      di_q      <= '0;
      rdata_q   <= '0;
      rd_only_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            mask_q    <= req_mask;
            rd_only_q <= req_rd_only;
            err_q     <= 1'b0;
          end
        end
        StRdReq, StWrReq: cnt_q <= '0;
        StRdWait: begin
          if (drp_rdy) begin
            rdata_q <= drp_do;
            di_q    <= (drp_do & ~mask_q) | (wdata_q & mask_q);
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWrWait: begin
          if (!drp_rdy) begin
            if (timeout) err_q <= 1'b1;
            else         cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign drp_addr  = addr_q;
  assign drp_di    = di_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_gtp_drp_rmw.sv
// Bench for gtp_drp_rmw: a behavioural DRP slave with programmable latency plus a
// reference register-file model predicting read data, merged writes and response timing.
module tb_gtp_drp_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rd_only;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata, req_mask;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic [7:0]  drp_addr;
  logic [15:0] drp_di, drp_do;
  logic        drp_en, drp_we, drp_rdy;

  logic        slave_rdy, stray_rdy;
  logic [15:0] slave_do, stray_do;
  assign drp_rdy = slave_rdy | stray_rdy;
  assign drp_do  = stray_rdy ? stray_do : slave_do;

  gtp_drp_rmw #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .req_rd_only(req_rd_only),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_en(drp_en), .drp_we(drp_we),
    .drp_do(drp_do), .drp_rdy(drp_rdy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Slave register file and reference model copy.
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] model_rdata = 16'h0;
  int  rd_lat = 2, wr_lat = 2;
  bit  mute = 1'b0;

  int          en_cyc[$], rsp_cyc[$], acc_cyc[$];
  bit          en_we[$], rsp_e[$];
  logic [7:0]  en_addr[$];
  logic [15:0] en_di[$], rsp_dat[$];
  int          err_bad = 0, addr_bad = 0;
  logic [7:0]  cur_addr = 8'h0;

  task automatic clear_logs();
    en_cyc.delete(); rsp_cyc.delete(); acc_cyc.delete(); en_we.delete(); rsp_e.delete();
    en_addr.delete(); en_di.delete(); rsp_dat.delete();
  endtask

  // DRP slave and bus monitor, evaluated mid-cycle.
  initial begin
    int cd;
    logic [7:0] pend_a;
    cd = 0; pend_a = 8'h0; slave_rdy = 1'b0; slave_do = 16'h0;
    forever begin
      @(negedge clk);
      slave_rdy = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !mute) begin slave_rdy = 1'b1; slave_do = mem[pend_a]; end
        end
        if (drp_en) begin
          en_cyc.push_back(cyc); en_we.push_back(drp_we);
          en_addr.push_back(drp_addr); en_di.push_back(drp_di);
          if (drp_we) mem[drp_addr] = drp_di;
          cd = drp_we ? wr_lat : rd_lat;
          pend_a = drp_addr;
        end
        if (rsp_valid) begin
          rsp_cyc.push_back(cyc); rsp_dat.push_back(rsp_rdata); rsp_e.push_back(rsp_err);
        end
        if (rsp_err && !rsp_valid) err_bad++;
        if (busy && drp_addr !== cur_addr) addr_bad++;
        if (req_valid && req_ready) begin acc_cyc.push_back(cyc); cur_addr = req_addr; end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] a, input logic [15:0] w, input logic [15:0] m,
                      input bit rd);
    @(posedge clk); #1;
    req_addr = a; req_wdata = w; req_mask = m; req_rd_only = rd; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rsp_cyc.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_rd_only = 1'b0; req_addr = 8'h0;
    req_wdata = 16'h0; req_mask = 16'h0; stray_rdy = 1'b0; stray_do = 16'h0;
    for (int i = 0; i < 256; i++) begin mem[i] = 16'($urandom); ref_mem[i] = mem[i]; end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else n_pass++;
    n_checks++; if ({drp_en, drp_we} !== 2'b00) $display("FAIL reset_en_we got %b want 00", {drp_en, drp_we});
    else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, busy} !== 3'b000)
      $display("FAIL reset_valid_err_busy got %b want 000", {rsp_valid, rsp_err, busy});
    else n_pass++;
    n_checks++; if ({drp_addr, drp_di, rsp_rdata} !== 40'h0)
      $display("FAIL reset_data got %h want 0", {drp_addr, drp_di, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_rmw();
    bit ok;
    mem[8'h11] = 16'h1234; ref_mem[8'h11] = 16'h1234;
    rd_lat = 2; wr_lat = 2; clear_logs();
    send(8'h11, 16'hABCD, 16'h00FF, 1'b0);
    wait_rsp(1, ok);
    n_checks++; if (!ok || en_cyc.size() != 2 || acc_cyc.size() != 1)
      $display("FAIL rmw_txn got ok=%0b en=%0d want ok=1 en=2", ok, en_cyc.size());
    else n_pass++;
    if (ok && en_cyc.size() == 2 && acc_cyc.size() == 1) begin
      n_checks++; if ({en_we[0], en_addr[0]} !== {1'b0, 8'h11} || en_cyc[0] != acc_cyc[0] + 1)
        $display("FAIL rmw_read_en got we=%b addr=%h cyc+%0d want we=0 addr=11 cyc+1",
                 en_we[0], en_addr[0], en_cyc[0] - acc_cyc[0]);
      else n_pass++;
      n_checks++; if ({en_we[1], en_addr[1], en_di[1]} !== {1'b1, 8'h11, 16'h12CD} ||
                      en_cyc[1] != acc_cyc[0] + 4)
        $display("FAIL rmw_write_en got we=%b di=%h cyc+%0d want we=1 di=12cd cyc+4",
                 en_we[1], en_di[1], en_cyc[1] - acc_cyc[0]);
      else n_pass++;
      n_checks++; if (rsp_dat[0] !== 16'h1234 || rsp_e[0] !== 1'b0 || rsp_cyc[0] != acc_cyc[0] + 7)
        $display("FAIL rmw_rsp got %h err=%b cyc+%0d want 1234 err=0 cyc+7",
                 rsp_dat[0], rsp_e[0], rsp_cyc[0] - acc_cyc[0]);
      else n_pass++;
    end
    ref_mem[8'h11] = 16'h12CD; model_rdata = 16'h1234;
  endtask

  task automatic test_rd_only();
    bit ok;
    mem[8'h22] = 16'h5A5A; ref_mem[8'h22] = 16'h5A5A;
    rd_lat = 2; clear_logs();
    send(8'h22, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_rsp(1, ok);
    repeat (5) @(negedge clk);
    n_checks++; if (!ok || en_cyc.size() != 1 || en_we[0] !== 1'b0)
      $display("FAIL rdonly_en got ok=%0b en=%0d want ok=1 en=1 we=0", ok, en_cyc.size());
    else n_pass++;
    if (ok && acc_cyc.size() == 1) begin
      n_checks++; if (rsp_dat[0] !== 16'h5A5A || rsp_cyc[0] != acc_cyc[0] + 4)
        $display("FAIL rdonly_rsp got %h cyc+%0d want 5a5a cyc+4", rsp_dat[0],
                 rsp_cyc[0] - acc_cyc[0]);
      else n_pass++;
    end
    model_rdata = 16'h5A5A;
  endtask

  task automatic test_stray_rdy();
    bit ok;
    logic [7:0] a;
    logic [15:0] old, w, m;
    a = 8'h60; old = ref_mem[a]; w = 16'($urandom); m = 16'($urandom);
    rd_lat = 3; wr_lat = 2; clear_logs();
    @(posedge clk); #1 stray_do = 16'hDEAD; stray_rdy = 1'b1;
    @(posedge clk); #1 stray_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_cyc.size() != 0)
      $display("FAIL stray_idle got busy=%b rsp=%0d want 0 0", busy, rsp_cyc.size());
    else n_pass++;
    @(posedge clk); #1;
    req_addr = a; req_wdata = w; req_mask = m; req_rd_only = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0; stray_do = ~old; stray_rdy = 1'b1;
    @(posedge clk); #1 stray_rdy = 1'b0;
    wait_rsp(1, ok);
    n_checks++; if (!ok || acc_cyc.size() != 1 || en_cyc.size() != 2)
      $display("FAIL stray_txn got ok=%0b en=%0d want ok=1 en=2", ok, en_cyc.size());
    else n_pass++;
    if (ok && acc_cyc.size() == 1 && en_cyc.size() == 2) begin
      n_checks++; if (rsp_dat[0] !== old || rsp_cyc[0] != acc_cyc[0] + 8)
        $display("FAIL stray_rsp got %h cyc+%0d want %h cyc+8", rsp_dat[0],
                 rsp_cyc[0] - acc_cyc[0], old);
      else n_pass++;
      n_checks++; if (en_di[1] !== ((old & ~m) | (w & m)))
        $display("FAIL stray_wdata got %h want %h", en_di[1], (old & ~m) | (w & m));
      else n_pass++;
    end
    ref_mem[a] = (old & ~m) | (w & m); model_rdata = old;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [15:0] old;
    mute = 1'b1; rd_lat = 2; clear_logs();
    send(8'h70, 16'h1111, 16'hFFFF, 1'b0);
    wait_rsp(1, ok);
    repeat (4) @(negedge clk);
    n_checks++; if (!ok || en_cyc.size() != 1 || en_we[0] !== 1'b0)
      $display("FAIL timeout_en got ok=%0b en=%0d want ok=1 en=1 we=0", ok, en_cyc.size());
    else n_pass++;
    if (ok && acc_cyc.size() == 1) begin
      n_checks++; if (rsp_e[0] !== 1'b1 || rsp_cyc[0] != acc_cyc[0] + 18)
        $display("FAIL timeout_rsp got err=%b cyc+%0d want err=1 cyc+18", rsp_e[0],
                 rsp_cyc[0] - acc_cyc[0]);
      else n_pass++;
      n_checks++; if (rsp_dat[0] !== model_rdata)
        $display("FAIL timeout_hold_rdata got %h want %h", rsp_dat[0], model_rdata);
      else n_pass++;
    end
    mute = 1'b0; clear_logs();
    old = ref_mem[8'h70];
    send(8'h70, 16'h1111, 16'h0000, 1'b0);
    wait_rsp(1, ok);
    n_checks++; if (!ok || rsp_e[0] !== 1'b0 || rsp_dat[0] !== old)
      $display("FAIL timeout_recover got ok=%0b err=%b data=%h want ok=1 err=0 data=%h",
               ok, rsp_e[0], rsp_dat[0], old);
    else n_pass++;
    n_checks++; if (en_cyc.size() != 2 || en_di[1] !== old)
      $display("FAIL mask0_writeback got en=%0d di=%h want en=2 di=%h", en_cyc.size(),
               en_di[1], old);
    else n_pass++;
    model_rdata = old;
  endtask

  task automatic test_random();
    bit ok, rd;
    logic [7:0] a;
    logic [15:0] w, m, old, nw;
    for (int t = 0; t < 24; t++) begin
      a = 8'($urandom_range(0, 7)); w = 16'($urandom); m = 16'($urandom);
      rd = ($urandom_range(0, 3) == 0);
      rd_lat = $urandom_range(1, 5); wr_lat = $urandom_range(1, 5);
      old = ref_mem[a]; nw = (old & ~m) | (w & m);
      clear_logs();
      send(a, w, m, rd);
      wait_rsp(1, ok);
      n_checks++; if (!ok || acc_cyc.size() != 1 || en_cyc.size() != (rd ? 1 : 2))
        $display("FAIL rand_txn t=%0d got ok=%0b en=%0d want ok=1 en=%0d", t, ok,
                 en_cyc.size(), rd ? 1 : 2);
      else n_pass++;
      if (ok && acc_cyc.size() == 1 && en_cyc.size() == (rd ? 1 : 2)) begin
        n_checks++; if (rsp_dat[0] !== old || rsp_e[0] !== 1'b0)
          $display("FAIL rand_rsp t=%0d got %h err=%b want %h err=0", t, rsp_dat[0],
                   rsp_e[0], old);
        else n_pass++;
        n_checks++;
        if (rsp_cyc[0] - acc_cyc[0] != (rd ? 2 + rd_lat : 3 + rd_lat + wr_lat))
          $display("FAIL rand_latency t=%0d got %0d want %0d", t, rsp_cyc[0] - acc_cyc[0],
                   rd ? 2 + rd_lat : 3 + rd_lat + wr_lat);
        else n_pass++;
        if (!rd) begin
          n_checks++; if ({en_we[0], en_we[1], en_addr[1], en_di[1]} !== {2'b01, a, nw})
            $display("FAIL rand_write t=%0d got we=%b%b addr=%h di=%h want we=01 addr=%h di=%h",
                     t, en_we[0], en_we[1], en_addr[1], en_di[1], a, nw);
          else n_pass++;
        end
      end
      if (!rd) ref_mem[a] = nw;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0]  a[3];
    logic [15:0] w[3], m[3], old[3], nw[3];
    int idx;
    a[0] = 8'h40; a[1] = 8'h40; a[2] = 8'h41;
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom); m[i] = 16'($urandom);
      old[i] = ref_mem[a[i]]; nw[i] = (old[i] & ~m[i]) | (w[i] & m[i]);
      ref_mem[a[i]] = nw[i];
    end
    rd_lat = $urandom_range(1, 3); wr_lat = $urandom_range(1, 3); clear_logs();
    @(posedge clk); #1;
    idx = 0; req_rd_only = 1'b0;
    req_addr = a[0]; req_wdata = w[0]; req_mask = m[0]; req_valid = 1'b1;
    for (int c = 0; c < 300 && idx < 3; c++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        idx++;
        if (idx == 3) req_valid = 1'b0;
        else begin req_addr = a[idx]; req_wdata = w[idx]; req_mask = m[idx]; end
      end
    end
    req_valid = 1'b0;
    wait_rsp(3, ok);
    n_checks++; if (!ok || acc_cyc.size() != 3 || en_cyc.size() != 6)
      $display("FAIL b2b_count got ok=%0b acc=%0d en=%0d want 1 3 6", ok, acc_cyc.size(),
               en_cyc.size());
    else n_pass++;
    if (ok && acc_cyc.size() == 3 && en_cyc.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (rsp_dat[i] !== old[i] || en_di[2*i+1] !== nw[i])
          $display("FAIL b2b_data i=%0d got rd=%h wr=%h want rd=%h wr=%h", i, rsp_dat[i],
                   en_di[2*i+1], old[i], nw[i]);
        else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (acc_cyc[i+1] != rsp_cyc[i] + 1)
          $display("FAIL b2b_accept i=%0d got cyc %0d want %0d", i, acc_cyc[i+1], rsp_cyc[i] + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0]  a;
    logic [15:0] w, m;
    for (int v = 0; v < 2; v++) begin
      a = 8'(8'h50 + v); w = 16'($urandom); m = 16'($urandom);
      rd_lat = 2; wr_lat = 30; clear_logs();
      send(a, w, m, 1'b0);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (drp_en && drp_we) break;
      end
      if (v == 1) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({drp_en, drp_we, busy, rsp_valid} !== 4'b0000)
        $display("FAIL midreset_v%0d got en/we/busy/valid=%b want 0000", v,
                 {drp_en, drp_we, busy, rsp_valid});
      else n_pass++;
      ref_mem[a] = (ref_mem[a] & ~m) | (w & m);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_checks++; if (rsp_cyc.size() != 0 || req_ready !== 1'b1 || rsp_rdata !== 16'h0)
        $display("FAIL midreset_after_v%0d got rsp=%0d ready=%b rdata=%h want 0 1 0000", v,
                 rsp_cyc.size(), req_ready, rsp_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_checks++; if (err_bad != 0) $display("FAIL err_without_valid got %0d want 0", err_bad);
    else n_pass++;
    n_checks++; if (addr_bad != 0) $display("FAIL addr_unstable got %0d want 0", addr_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rmw();
    test_rd_only();
    test_stray_rdy();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
